// File: rtl/dso_key_ctrl_pkg.sv
// Shared definitions for the DSO front-panel key controller: parameter-select
// encodings, power-up defaults for the acquisition settings and the saturating
// step helpers used by the setting registers.
package dso_key_ctrl_pkg;

   // Active parameter selected by the mode key; encoding 3 is never produced.
   typedef enum logic [1:0] {
      MODE_LEVEL = 2'd0,
      MODE_DECI  = 2'd1,
      MODE_EDGE  = 2'd2
   } mode_e;

   // Key slots, in the order the raw pins are packed inside the controller.
   localparam int KEY_RUN  = 0;
   localparam int KEY_MODE = 1;
   localparam int KEY_UP   = 2;
   localparam int KEY_DOWN = 3;
   localparam int NUM_KEYS = 4;

   // Power-up settings: running, mid-scale trigger, no decimation, rising edge.
   localparam logic       RUN_RST        = 1'b1;
   localparam logic [7:0] TRIG_LEVEL_RST = 8'd127;
   localparam logic [9:0] DECI_RST       = 10'd1;
   localparam logic       TRIG_EDGE_RST  = 1'b1;

   // Trigger level +/- step, computed with a ninth bit so overflow and
   // underflow are visible before clamping to 255 / 0.
   function automatic logic [7:0] level_step(input logic [7:0] level,
                                             input logic       up,
                                             input logic [7:0] step);
      logic [8:0] wide;
      if (up) begin
         wide       = {1'b0, level} + {1'b0, step};
         level_step = wide[8] ? 8'hFF : wide[7:0];
      end else begin
         wide       = {1'b0, level} - {1'b0, step};
         level_step = wide[8] ? 8'h00 : wide[7:0];
      end
   endfunction

   // Decimation rate +/- 1, held inside 1..max.
   function automatic logic [9:0] deci_step(input logic [9:0] rate,
                                            input logic       up,
                                            input logic [9:0] max);
      if (up) deci_step = (rate >= max)   ? max   : rate + 10'd1;
      else    deci_step = (rate <= 10'd1) ? 10'd1 : rate - 10'd1;
   endfunction

   // LEVEL -> DECI -> EDGE -> LEVEL; the unused encoding falls back to LEVEL.
   function automatic mode_e next_mode(input mode_e mode);
      case (mode)
         MODE_LEVEL: next_mode = MODE_DECI;
         MODE_DECI:  next_mode = MODE_EDGE;
         default:    next_mode = MODE_LEVEL;
      endcase
   endfunction

endpackage

// File: rtl/dso_key_ctrl_key_debounce.sv
// One front-panel key: 2-FF synchroniser, polarity normalised to pressed=1,
// then a ms-tick debouncer that reports the stable level (hold) and a
// one-cycle pulse on each stable press.
module key_debounce #(
   parameter logic KEY_ACT_LOW = 1'b1,
   parameter int   DEB_MS      = 20
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic ms_tick,
   input  logic key_pin,
   output logic press,
   output logic hold
);

   localparam int   CNT_W    = $clog2(DEB_MS + 1);
   localparam logic PIN_IDLE = KEY_ACT_LOW;

   logic [1:0]       sync;
   logic             key_lvl;
   logic             stable;
   logic [CNT_W-1:0] deb_cnt;

   // Bring the asynchronous pin into the sys_clk domain; resets to "released".
   // NOTE: registers are updated with <= so every flop samples the pre-edge
   // value of its neighbours, which is what makes the 2-FF chain two stages.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) sync <= {2{PIN_IDLE}};
      else            sync <= {sync[0], key_pin};
   end

   assign key_lvl = sync[1] ^ KEY_ACT_LOW;

   // Accept a new level only after it has differed from the stable one for
   // DEB_MS consecutive ticks; any agreeing sample restarts the count.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         stable  <= 1'b0;
         deb_cnt <= '0;
         press   <= 1'b0;
      end else begin
         press <= 1'b0;
         if (key_lvl == stable) begin
            deb_cnt <= '0;
         end else if (ms_tick) begin
            if (deb_cnt == CNT_W'(DEB_MS - 1)) begin
               stable  <= key_lvl;
               deb_cnt <= '0;
               press   <= key_lvl;
            end else begin
               deb_cnt <= deb_cnt + 1'b1;
            end
         end
      end
   end

   assign hold = stable;

endmodule

// File: rtl/dso_key_ctrl.sv
// DSO front-panel control: debounces run/mode/up/down keys, auto-repeats
// up/down while held, and keeps the acquisition settings (run, trigger level,
// decimation rate, trigger edge) plus the parameter-select state.
module dso_key_ctrl
   import dso_key_ctrl_pkg::*;
#(
   parameter int   CLK_FS       = 50_000_000,
   parameter logic KEY_ACT_LOW  = 1'b1,
   parameter int   DEB_MS       = 20,
   parameter int   RPT_START_MS = 500,
   parameter int   RPT_MS       = 100,
   parameter int   TRIG_STEP    = 4,
   parameter int   DECI_MAX     = 1000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_run,
   input  logic       key_mode,
   input  logic       key_up,
   input  logic       key_down,
   output logic       wave_run,
   output logic [7:0] trig_level,
   output logic [9:0] deci_rate,
   output logic       trig_edge,
   output logic [1:0] sel_mode,
   output logic       param_chg
);

   localparam int TICK_DIV = CLK_FS / 1000;
   localparam int TICK_W   = $clog2(TICK_DIV);
   localparam int RPT_W    = $clog2(RPT_START_MS + 1);

   logic [TICK_W-1:0]   tick_cnt;
   logic                ms_tick;
   logic [NUM_KEYS-1:0] key_pins;
   logic [NUM_KEYS-1:0] press_v;
   logic [NUM_KEYS-1:0] hold_v;
   logic [RPT_W-1:0]    rpt_cnt [2];
   logic [1:0]          rpt;
   logic                step_up;
   logic                step_dn;
   logic                unused_hold;
   mode_e               mode_q;

   logic       nxt_run;
   logic [7:0] nxt_level;
   logic [9:0] nxt_deci;
   logic       nxt_edge;

   // Free-running millisecond tick shared by all debouncers and the repeaters.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tick_cnt <= '0;
         ms_tick  <= 1'b0;
      end else if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
         tick_cnt <= '0;
         ms_tick  <= 1'b1;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
         ms_tick  <= 1'b0;
      end
   end

   assign key_pins = {key_down, key_up, key_mode, key_run};

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_debounce #(
         .KEY_ACT_LOW (KEY_ACT_LOW),
         .DEB_MS      (DEB_MS)
      ) u_deb (
         .sys_clk   (sys_clk),
         .sys_rst_n (sys_rst_n),
         .ms_tick   (ms_tick),
         .key_pin   (key_pins[k]),
         .press     (press_v[k]),
         .hold      (hold_v[k])
      );
   end

   // Run and mode act on presses only; their held level has no consumer.
   assign unused_hold = ^hold_v[KEY_MODE:KEY_RUN];

   // Auto-repeat for up (slot 0) and down (slot 1): first pulse RPT_START_MS
   // ticks into the hold, then every RPT_MS by rewinding the counter.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rpt <= '0;
         for (int i = 0; i < 2; i++) rpt_cnt[i] <= '0;
      end else begin
         rpt <= '0;
         for (int i = 0; i < 2; i++) begin
            if (!hold_v[KEY_UP + i]) begin
               rpt_cnt[i] <= '0;
            end else if (ms_tick) begin
               if (rpt_cnt[i] == RPT_W'(RPT_START_MS - 1)) begin
                  rpt[i]     <= 1'b1;
                  rpt_cnt[i] <= RPT_W'(RPT_START_MS - RPT_MS);
               end else begin
                  rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
               end
            end
         end
      end
   end

   assign step_up = press_v[KEY_UP]   | rpt[0];
   assign step_dn = press_v[KEY_DOWN] | rpt[1];

   // Parameter-select FSM; a stray encoding returns to LEVEL on the next edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mode_q <= MODE_LEVEL;
      end else begin
         case (mode_q)
            MODE_LEVEL, MODE_DECI, MODE_EDGE:
               if (press_v[KEY_MODE]) mode_q <= next_mode(mode_q);
            default:
               mode_q <= MODE_LEVEL;
         endcase
      end
   end

   assign sel_mode = mode_q;

   // Next settings: steps act on the mode in force before any same-cycle mode
   // press, and opposing steps cancel.
   // NOTE: every output of this block gets a default first so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      nxt_run   = wave_run;
      nxt_level = trig_level;
      nxt_deci  = deci_rate;
      nxt_edge  = trig_edge;
      if (press_v[KEY_RUN]) nxt_run = ~wave_run;
      if (step_up ^ step_dn) begin
         case (mode_q)
            MODE_LEVEL: nxt_level = level_step(trig_level, step_up, 8'(TRIG_STEP));
            MODE_DECI:  nxt_deci  = deci_step(deci_rate, step_up, 10'(DECI_MAX));
            MODE_EDGE:  nxt_edge  = ~trig_edge;
            default:    ;
         endcase
      end
   end

   // Setting registers; param_chg flags only steps that really moved a value.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wave_run   <= RUN_RST;
         trig_level <= TRIG_LEVEL_RST;
         deci_rate  <= DECI_RST;
         trig_edge  <= TRIG_EDGE_RST;
         param_chg  <= 1'b0;
      end else begin
         wave_run   <= nxt_run;
         trig_level <= nxt_level;
         deci_rate  <= nxt_deci;
         trig_edge  <= nxt_edge;
         param_chg  <= (nxt_run != wave_run) || (nxt_level != trig_level) ||
                       (nxt_deci != deci_rate) || (nxt_edge != trig_edge);
      end
   end

endmodule

// File: tb/tb_dso_key_ctrl.sv
// Self-checking bench for dso_key_ctrl. The tick is scaled to 100 cycles/ms
// so long holds (saturation, repeat) stay short; debounce and repeat times
// are the small values DEB_MS=2, RPT_START_MS=5, RPT_MS=2.
module tb_dso_key_ctrl;

   localparam int MS = 100;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       key_run = 1'b1, key_mode = 1'b1, key_up = 1'b1, key_down = 1'b1;
   logic       wave_run;
   logic [7:0] trig_level;
   logic [9:0] deci_rate;
   logic       trig_edge;
   logic [1:0] sel_mode;
   logic       param_chg;

   int n_checks = 0;
   int n_fail   = 0;
   int chg_cnt  = 0;

   dso_key_ctrl #(
      .CLK_FS       (100_000),
      .KEY_ACT_LOW  (1'b1),
      .DEB_MS       (2),
      .RPT_START_MS (5),
      .RPT_MS       (2),
      .TRIG_STEP    (4),
      .DECI_MAX     (1000)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key_run    (key_run),
      .key_mode   (key_mode),
      .key_up     (key_up),
      .key_down   (key_down),
      .wave_run   (wave_run),
      .trig_level (trig_level),
      .deci_rate  (deci_rate),
      .trig_edge  (trig_edge),
      .sel_mode   (sel_mode),
      .param_chg  (param_chg)
   );

   always #5 sys_clk = ~sys_clk;

   // Count every param_chg pulse, sampled away from the active edge.
   always @(negedge sys_clk) if (param_chg === 1'b1) chg_cnt++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0] keys;     // {down, up, mode, run}, 1 = pressed
      logic       run;
      logic [7:0] level;
      logic [9:0] deci;
      logic       edge_r;
      logic [1:0] mode;
      int         chg;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic set_keys(input logic [3:0] k);
      key_run  = ~k[0];
      key_mode = ~k[1];
      key_up   = ~k[2];
      key_down = ~k[3];
   endtask

   // Short press (2.5 ms, below the repeat threshold) and full release.
   task automatic tap(input logic [3:0] k);
      set_keys(k);
      cycles(250);
      set_keys(4'b0000);
      cycles(300);
   endtask

   task automatic check_state(input string tag, input logic run, input logic [7:0] level,
                              input logic [9:0] deci, input logic edge_r, input logic [1:0] mode);
      check({tag, " wave_run"},   wave_run,   run);
      check({tag, " trig_level"}, trig_level, level);
      check({tag, " deci_rate"},  deci_rate,  deci);
      check({tag, " trig_edge"},  trig_edge,  edge_r);
      check({tag, " sel_mode"},   sel_mode,   mode);
   endtask

   // Cycles until trig_level moves away from its current value, bounded.
   task automatic wait_level_change(input int budget, output int waited);
      logic [7:0] prev;
      prev   = trig_level;
      waited = 0;
      while (trig_level == prev && waited < budget) begin
         cycles(1);
         waited++;
      end
   endtask

   vec_t vecs [$];

   initial begin
      int c0, lat, gap;
      int m_run, m_level, m_deci, m_edge, m_mode, m_chg;
      int o_run, o_level, o_deci, o_edge;
      logic [3:0] k;

      // ---------------- reset and idle ----------------
      set_keys(4'b0000);
      cycles(3);
      check_state("in reset", 1'b1, 8'd127, 10'd1, 1'b1, 2'd0);
      check("in reset param_chg", param_chg, 1'b0);
      sys_rst_n = 1'b1;
      cycles(20 * MS);
      check_state("idle", 1'b1, 8'd127, 10'd1, 1'b1, 2'd0);
      check("idle param_chg count", chg_cnt, 0);

      // ---------------- bouncing run key ----------------
      c0 = chg_cnt;
      for (int i = 0; i < 5; i++) begin
         set_keys((i % 2 == 0) ? 4'b0001 : 4'b0000);
         cycles(30);
      end
      check("bounce no toggle yet", wave_run, 1'b1);
      set_keys(4'b0001);
      cycles(3 * MS);
      set_keys(4'b0000);
      cycles(3 * MS);
      check("bounce wave_run", wave_run, 1'b0);
      check("bounce param_chg count", chg_cnt - c0, 1);

      // ---------------- held up key: press, then repeat at +5 ms, +7 ms -------
      c0 = chg_cnt;
      set_keys(4'b0100);
      wait_level_change(4 * MS, lat);
      check("press latency in 1..2 ms window", (lat >= MS && lat <= 2 * MS + 10), 1'b1);
      check("first step level", trig_level, 8'd131);
      wait_level_change(8 * MS, gap);
      check("repeat start interval", gap, 5 * MS);
      check("second step level", trig_level, 8'd135);
      cycles(150);
      set_keys(4'b0000);
      wait_level_change(4 * MS, lat);
      check("repeat interval", lat + 150, 2 * MS);
      cycles(6 * MS);
      check("hold-up final level", trig_level, 8'd139);
      check("hold-up param_chg count", chg_cnt - c0, 3);

      // ---------------- saturation ----------------
      c0 = chg_cnt;
      set_keys(4'b0100);
      cycles(80 * MS);
      check("level saturates high", trig_level, 8'd255);
      check("saturated steps give no pulse", chg_cnt - c0, 29);
      set_keys(4'b0000);
      cycles(3 * MS);
      c0 = chg_cnt;
      tap(4'b0010);
      check("mode to DECI", sel_mode, 2'd1);
      check("mode press no pulse", chg_cnt - c0, 0);
      set_keys(4'b1000);
      cycles(20 * MS);
      set_keys(4'b0000);
      cycles(3 * MS);
      check("deci saturates low", deci_rate, 10'd1);
      check("deci floor no pulse", chg_cnt - c0, 0);

      // ---------------- table of taps (simultaneity included) ----------------
      vecs.push_back('{4'b0100, 1'b0, 8'd255, 10'd2, 1'b1, 2'd1, 1});
      vecs.push_back('{4'b0100, 1'b0, 8'd255, 10'd3, 1'b1, 2'd1, 1});
      vecs.push_back('{4'b1000, 1'b0, 8'd255, 10'd2, 1'b1, 2'd1, 1});
      vecs.push_back('{4'b1100, 1'b0, 8'd255, 10'd2, 1'b1, 2'd1, 0});
      vecs.push_back('{4'b0010, 1'b0, 8'd255, 10'd2, 1'b1, 2'd2, 0});
      vecs.push_back('{4'b1000, 1'b0, 8'd255, 10'd2, 1'b0, 2'd2, 1});
      vecs.push_back('{4'b1100, 1'b0, 8'd255, 10'd2, 1'b0, 2'd2, 0});
      vecs.push_back('{4'b0011, 1'b1, 8'd255, 10'd2, 1'b0, 2'd0, 1});
      vecs.push_back('{4'b1000, 1'b1, 8'd251, 10'd2, 1'b0, 2'd0, 1});
      vecs.push_back('{4'b0110, 1'b1, 8'd255, 10'd2, 1'b0, 2'd1, 1});
      vecs.push_back('{4'b0100, 1'b1, 8'd255, 10'd3, 1'b0, 2'd1, 1});
      vecs.push_back('{4'b0001, 1'b0, 8'd255, 10'd3, 1'b0, 2'd1, 1});
      vecs.push_back('{4'b0010, 1'b0, 8'd255, 10'd3, 1'b0, 2'd2, 0});
      vecs.push_back('{4'b0100, 1'b0, 8'd255, 10'd3, 1'b1, 2'd2, 1});
      vecs.push_back('{4'b0010, 1'b0, 8'd255, 10'd3, 1'b1, 2'd0, 0});
      vecs.push_back('{4'b1110, 1'b0, 8'd255, 10'd3, 1'b1, 2'd1, 0});
      foreach (vecs[i]) begin
         c0 = chg_cnt;
         tap(vecs[i].keys);
         check_state($sformatf("vec%0d", i), vecs[i].run, vecs[i].level,
                     vecs[i].deci, vecs[i].edge_r, vecs[i].mode);
         check($sformatf("vec%0d param_chg count", i), chg_cnt - c0, vecs[i].chg);
      end

      // ---------------- random taps against a settings model ----------------
      m_run = 0; m_level = 255; m_deci = 3; m_edge = 1; m_mode = 1;
      for (int i = 0; i < 15; i++) begin
         k = 4'($urandom_range(1, 15));
         o_run = m_run; o_level = m_level; o_deci = m_deci; o_edge = m_edge;
         if (k[0]) m_run = 1 - m_run;
         if (k[2] != k[3]) begin
            if (m_mode == 0) begin
               m_level = k[2] ? m_level + 4 : m_level - 4;
               if (m_level > 255) m_level = 255;
               if (m_level < 0)   m_level = 0;
            end else if (m_mode == 1) begin
               m_deci = k[2] ? m_deci + 1 : m_deci - 1;
               if (m_deci > 1000) m_deci = 1000;
               if (m_deci < 1)    m_deci = 1;
            end else begin
               m_edge = 1 - m_edge;
            end
         end
         if (k[1]) m_mode = (m_mode + 1) % 3;
         m_chg = (m_run != o_run || m_level != o_level ||
                  m_deci != o_deci || m_edge != o_edge) ? 1 : 0;
         c0 = chg_cnt;
         tap(k);
         check_state($sformatf("rand%0d k=%b", i, k), 1'(m_run), 8'(m_level),
                     10'(m_deci), 1'(m_edge), 2'(m_mode));
         check($sformatf("rand%0d param_chg count", i), chg_cnt - c0, m_chg);
      end

      // ---------------- asynchronous reset mid-repeat ----------------
      set_keys(4'b0100);
      cycles(9 * MS);
      #3;
      sys_rst_n = 1'b0;
      #1;
      check_state("async reset", 1'b1, 8'd127, 10'd1, 1'b1, 2'd0);
      check("async reset param_chg", param_chg, 1'b0);
      cycles(3);
      sys_rst_n = 1'b1;
      wait_level_change(4 * MS, lat);
      check("held-through-reset latency", (lat >= MS && lat <= 2 * MS + 10), 1'b1);
      check("held-through-reset level", trig_level, 8'd131);
      set_keys(4'b0000);
      cycles(3 * MS);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
